d_mem_lsu: RTL

Load/store sequencer between the core's memory stage and d_mem_spram.
- Accepts one request at a time over a valid/ready handshake and registers it.
- Holds address, width and sign_extend stable across the SPRAM registered-read cycle, so the memory's combinational alignment and extension see consistent controls.
- Returns exactly one response per request, loads and stores alike.
- Rejects accesses whose misaligned span would wrap past the top of data memory.

---
 rtl/d_mem_lsu_pkg.sv | 29 ++
 rtl/d_mem_span_check.sv | 21 ++
 rtl/d_mem_lsu.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/d_mem_lsu_pkg.sv
// Shared types and helpers for the data-memory load/store sequencer and its span checker.
// DMemAddrWidth is the byte-address width of data memory.
package d_mem_lsu_pkg;

  localparam int DMemAddrWidth = 12;

  typedef enum logic [1:0] {
    BYTE     = 2'd0,
    HALFWORD = 2'd1,
    WORD     = 2'd2
  } mem_width_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } lsu_state_t;

  function automatic logic [2:0] width_bytes(input mem_width_t width);
    case (width)
      BYTE:     width_bytes = 3'd1;
      HALFWORD: width_bytes = 3'd2;
      WORD:     width_bytes = 3'd4;
      default:  width_bytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/d_mem_span_check.sv
// Flags accesses whose bytes would run past the last word of memory and wrap to address 0.
// Purely combinational so the instruction-fetch side can reuse it.
module d_mem_span_check
  import d_mem_lsu_pkg::*;
#(
  parameter int AddrWidth = DMemAddrWidth
) (
  input  logic [AddrWidth-1:0] addr_i,
  input  mem_width_t           width_i,
  output logic                 err_o
);

  logic [2:0] span_s;

  // Worst case is offset 3 plus a word, 7 bytes, which still fits in 3 bits.
  always_comb begin
    span_s = {1'b0, addr_i[1:0]} + width_bytes(width_i);
    err_o  = (span_s > 3'd4) && (&addr_i[AddrWidth-1:2]);
  end

endmodule

// File: rtl/d_mem_lsu.sv
// Load/store sequencer between the memory stage and d_mem_spram: one request in flight, one response out.
// Optional D_MEM_LSU_FAST_RESP_EN presents load data combinationally in CAPTURE to save a cycle.
module d_mem_lsu
  import d_mem_lsu_pkg::*;
#(
  parameter int AddrWidth = DMemAddrWidth
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  mem_width_t           req_width,
  input  logic                 req_sign_extend,
  input  logic [AddrWidth-1:0] req_addr,
  input  logic [31:0]          req_wdata,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [31:0]          resp_rdata,
  output logic                 resp_err,
  output logic [AddrWidth-1:0] mem_addr,
  output mem_width_t           mem_width,
  output logic                 mem_sign_extend,
  output logic [31:0]          mem_data_in,
  output logic                 mem_write_enable,
  input  logic [31:0]          mem_data_out
);

  lsu_state_t           state_q;
  logic                 req_ready_q;
  logic [AddrWidth-1:0] addr_q;
  mem_width_t           width_q;
  logic                 sext_q;
  logic [31:0]          wdata_q;
  logic                 we_q;
  logic                 mem_we_q;
  logic                 resp_valid_q;
  logic [31:0]          rdata_q;
  logic                 err_q;
  logic                 span_err_s;

  d_mem_span_check #(
    .AddrWidth(AddrWidth)
  ) u_span_check (
    .addr_i (req_addr),
    .width_i(req_width),
    .err_o  (span_err_s)
  );

  // Sequencer FSM; memory controls come only from the hold registers so they stay put through the read.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      req_ready_q  <= 1'b1;
      addr_q       <= {AddrWidth{1'b0}};
      width_q      <= WORD;
      sext_q       <= 1'b0;
      wdata_q      <= 32'h0000_0000;
      we_q         <= 1'b0;
      mem_we_q     <= 1'b0;
      resp_valid_q <= 1'b0;
      rdata_q      <= 32'h0000_0000;
      err_q        <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            req_ready_q <= 1'b0;
            rdata_q     <= 32'h0000_0000;
            err_q       <= span_err_s;
            if (span_err_s) begin
              // A wrapping span never reaches memory, so the hold registers keep their old values.
              state_q      <= RESP;
              resp_valid_q <= 1'b1;
            end else begin
              addr_q   <= req_addr;
              width_q  <= req_width;
              sext_q   <= req_sign_extend;
              wdata_q  <= req_wdata;
              we_q     <= req_we;
              mem_we_q <= req_we;
              state_q  <= ISSUE;
            end
          end
        end
        ISSUE: begin
          mem_we_q <= 1'b0;
          if (we_q) begin
            state_q      <= RESP;
            resp_valid_q <= 1'b1;
          end else begin
            state_q <= CAPTURE;
          end
        end
        CAPTURE: begin
          rdata_q <= mem_data_out;
`ifdef D_MEM_LSU_FAST_RESP_EN
          if (resp_ready) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b1;
          end else begin
            state_q      <= RESP;
            resp_valid_q <= 1'b1;
          end
`else
          state_q      <= RESP;
          resp_valid_q <= 1'b1;
`endif
        end
        RESP: begin
          if (resp_ready) begin
            state_q      <= IDLE;
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q      <= IDLE;
          req_ready_q  <= 1'b1;
          mem_we_q     <= 1'b0;
          resp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready        = req_ready_q;
  assign resp_err         = err_q;
  assign mem_addr         = addr_q;
  assign mem_width        = width_q;
  assign mem_sign_extend  = sext_q;
  assign mem_data_in      = wdata_q;
  assign mem_write_enable = mem_we_q;

`ifdef D_MEM_LSU_FAST_RESP_EN
  assign resp_valid = resp_valid_q | (state_q == CAPTURE);
  assign resp_rdata = (state_q == CAPTURE) ? mem_data_out : rdata_q;
`else
  assign resp_valid = resp_valid_q;
  assign resp_rdata = rdata_q;
`endif

endmodule
